// File: rtl/signmag_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready on both sides.
// Optional macro SIGNMAG_ADDSUB_SAT_EN saturates the magnitude of an overflowing add.
module signmag_addsub_pipe #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             sign_a,
    input  logic [WIDTH-1:0] mag_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] mag_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             sign,
    output logic             carry,
    output logic             zero
);

    logic             s1_valid_q;
    logic             s1_sub_q;
    logic             s1_sign_q;
    logic [WIDTH-1:0] s1_big_q;
    logic [WIDTH-1:0] s1_small_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             sign_q;
    logic             carry_q;
    logic             zero_q;

    logic             s1_adv;
    logic             s2_adv;
    logic             accept;

    logic             s1_sub_d;
    logic             s1_sign_d;
    logic [WIDTH-1:0] s1_big_d;
    logic [WIDTH-1:0] s1_small_d;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] res_d;
    logic             sign_d;
    logic             carry_d;
    logic             zero_d;

    logic             eb;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    // Stage 1: fold op into B's sign and order operands so that big >= small.
    always_comb begin
        eb        = sign_b ^ op;
        s1_sub_d  = sign_a ^ eb;
        s1_big_d  = mag_a;
        s1_small_d = mag_b;
        s1_sign_d = sign_a;
        if (mag_b > mag_a) begin
            s1_big_d   = mag_b;
            s1_small_d = mag_a;
            s1_sign_d  = eb;
        end
    end

    // Stage 2: the subtract never underflows because of the ordering above.
    always_comb begin
        if (s1_sub_q) begin
            sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        end else begin
            sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
        end
        carry_d = !s1_sub_q && sum_d[WIDTH];
`ifdef SIGNMAG_ADDSUB_SAT_EN
        res_d = carry_d ? {WIDTH{1'b1}} : sum_d[WIDTH-1:0];
`else
        res_d = sum_d[WIDTH-1:0];
`endif
        zero_d = (res_d == '0) && !carry_d;
        sign_d = zero_d ? 1'b0 : s1_sign_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_big_q   <= '0;
            s1_small_q <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            sign_q     <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_sub_q   <= s1_sub_d;
                s1_sign_q  <= s1_sign_d;
                s1_big_q   <= s1_big_d;
                s1_small_q <= s1_small_d;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                res_q   <= res_d;
                sign_q  <= sign_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign res       = res_q;
    assign sign      = sign_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_signmag_addsub_pipe.sv
// Scoreboard bench for signmag_addsub_pipe: driver pushes expected results,
// a negedge monitor pops and compares whenever a result is transferred.
module tb_signmag_addsub_pipe;

    localparam int W = 25;
    localparam longint MOD = 64'sd1 << W;

    typedef struct {
        logic [W-1:0] res;
        logic         sign;
        logic         carry;
        logic         zero;
        int           acc;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic         sign_a = 1'b0;
    logic [W-1:0] mag_a = '0;
    logic         sign_b = 1'b0;
    logic [W-1:0] mag_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] res;
    logic         sign;
    logic         carry;
    logic         zero;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    logic         prev_stall = 1'b0;
    logic [W-1:0] snap_res;
    logic         snap_sign, snap_carry, snap_zero;

    signmag_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sign_a(sign_a), .mag_a(mag_a), .sign_b(sign_b), .mag_b(mag_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .sign(sign), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the signed arithmetic value of A op B, then split into fields.
    function automatic exp_t model(input logic o, input logic sa, input logic [W-1:0] ma,
                                   input logic sb, input logic [W-1:0] mb);
        exp_t   e;
        longint va, vb, r, m;
        va = sa ? -longint'(ma) : longint'(ma);
        vb = sb ? -longint'(mb) : longint'(mb);
        r  = o ? va - vb : va + vb;
        m  = (r < 0) ? -r : r;
        e.carry = (m >= MOD);
        e.res   = W'(m % MOD);
`ifdef SIGNMAG_ADDSUB_SAT_EN
        if (e.carry) e.res = '1;
`endif
        e.zero = (m == 0);
        e.sign = (r < 0);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic s, input logic c, input logic z);
        exp_t e;
        e.res = r; e.sign = s; e.carry = c; e.zero = z; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Monitor: compares every transferred result and checks stability under stall.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                n_cmp++;
                if ({res, sign, carry, zero} !== {snap_res, snap_sign, snap_carry, snap_zero}) begin
                    n_err++;
                    $display("FAIL stall_stable: got res=%h s=%b c=%b z=%b, want res=%h s=%b c=%b z=%b",
                             res, sign, carry, zero, snap_res, snap_sign, snap_carry, snap_zero);
                end
            end
            if (out_valid && out_ready) begin
                exp_t e;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got res=%h s=%b c=%b z=%b, want no output",
                             res, sign, carry, zero);
                end else begin
                    e = sb_q.pop_front();
                    $display("result res=%h sign=%b carry=%b zero=%b (cycle %0d)", res, sign, carry, zero, cyc);
                    if ({res, sign, carry, zero} !== {e.res, e.sign, e.carry, e.zero}) begin
                        n_err++;
                        $display("FAIL result: got res=%h s=%b c=%b z=%b, want res=%h s=%b c=%b z=%b",
                                 res, sign, carry, zero, e.res, e.sign, e.carry, e.zero);
                    end
                    if (e.lat) begin
                        n_cmp++;
                        if (cyc - e.acc != 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d cycles, want 2", cyc - e.acc);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            snap_res = res; snap_sign = sign; snap_carry = carry; snap_zero = zero;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive(input logic o, input logic sa, input logic [W-1:0] ma,
                         input logic sb, input logic [W-1:0] mb);
        op = o; sign_a = sa; mag_a = ma; sign_b = sb; mag_b = mb; in_valid = 1'b1;
    endtask

    // Present one set from the next cycle and hold it until accepted.
    task automatic send(input logic o, input logic sa, input logic [W-1:0] ma,
                        input logic sb, input logic [W-1:0] mb, input exp_t e, input bit lat);
        int waits;
        @(posedge clk); #1;
        drive(o, sa, ma, sb, mb);
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", waits);
                return;
            end
        end
        e.acc = cyc;
        e.lat = lat;
        sb_q.push_back(e);
        if (lat) begin
            n_cmp++;
            if (waits != 0) begin
                n_err++;
                $display("FAIL in_ready_full_rate: got %0d stall cycles, want 0", waits);
            end
        end
    endtask

    task automatic send_dir(input logic o, input logic sa, input logic [W-1:0] ma,
                            input logic sb, input logic [W-1:0] mb, input exp_t e);
        send(o, sa, ma, sb, mb, e, 1'b1);
    endtask

    task automatic rand_set(output logic o, output logic sa, output logic [W-1:0] ma,
                            output logic sb, output logic [W-1:0] mb);
        o  = 1'($urandom);
        sa = 1'($urandom);
        sb = 1'($urandom);
        ma = W'($urandom);
        mb = W'($urandom);
        case ($urandom_range(0, 7))
            0: mb = ma;
            1: begin ma = '1; mb = '1; end
            2: ma = '0;
            3: begin ma = '0; mb = '0; end
            default: ;
        endcase
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding, want 0", sb_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         o, sa, sb;
        logic [W-1:0] ma, mb;
        int           acc;

        // Reset state while rst is held
        #12;
        n_cmp++;
        if ({out_valid, res, sign, carry, zero} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b res=%h s=%b c=%b z=%b, want v=0 res=0 s=0 c=0 z=1",
                     out_valid, res, sign, carry, zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_after_reset: got %b, want 1", in_ready);
        end

        // Directed sign/cancellation/overflow cases
        send_dir(1'b1, 1'b0, W'(5), 1'b0, W'(9), mk(W'(4), 1'b1, 1'b0, 1'b0));
        send_dir(1'b0, 1'b1, W'(5), 1'b1, W'(9), mk(W'(14), 1'b1, 1'b0, 1'b0));
        send_dir(1'b1, 1'b0, W'(9), 1'b1, W'(5), mk(W'(14), 1'b0, 1'b0, 1'b0));
        send_dir(1'b1, 1'b0, W'(32'h123456), 1'b0, W'(32'h123456), mk('0, 1'b0, 1'b0, 1'b1));
        send_dir(1'b0, 1'b1, W'(7), 1'b0, W'(7), mk('0, 1'b0, 1'b0, 1'b1));
`ifdef SIGNMAG_ADDSUB_SAT_EN
        send_dir(1'b0, 1'b0, W'(32'h1FFFFFF), 1'b0, W'(32'h1FFFFFF), mk(W'(32'h1FFFFFF), 1'b0, 1'b1, 1'b0));
`else
        send_dir(1'b0, 1'b0, W'(32'h1FFFFFF), 1'b0, W'(32'h1FFFFFF), mk(W'(32'h1FFFFFE), 1'b0, 1'b1, 1'b0));
`endif
        // Negative-zero operands still steer eb/sub but must not yield -0
        send_dir(1'b0, 1'b1, '0, 1'b1, '0, mk('0, 1'b0, 1'b0, 1'b1));

        // Back-to-back random sets at full rate
        for (int i = 0; i < 100; i++) begin
            rand_set(o, sa, ma, sb, mb);
            send(o, sa, ma, sb, mb, model(o, sa, ma, sb, mb), 1'b1);
        end
        idle();
        drain();

        // Mid-stream reset with two sets in flight
        send(1'b0, 1'b0, W'(100), 1'b0, W'(200), mk(W'(300), 1'b0, 1'b0, 1'b0), 1'b0);
        send(1'b0, 1'b0, W'(1), 1'b0, W'(2), mk(W'(3), 1'b0, 1'b0, 1'b0), 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, res, carry, zero} !== {1'b0, {W{1'b0}}, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b res=%h c=%b z=%b, want v=0 res=0 c=0 z=1",
                     out_valid, res, carry, zero);
        end
        sb_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_after_midreset: got %b, want 1", in_ready);
        end
        repeat (5) @(posedge clk);

        // Backpressure: five stalled cycles fill exactly two stages
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_set(o, sa, ma, sb, mb);
        drive(o, sa, ma, sb, mb);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e = model(o, sa, ma, sb, mb);
                sb_q.push_back(e);
                acc++;
                @(posedge clk); #1;
                rand_set(o, sa, ma, sb, mb);
                drive(o, sa, ma, sb, mb);
            end else begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (acc != 2) begin
            n_err++;
            $display("FAIL stall_accepts: got %0d, want 2", acc);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_in_ready: got %b, want 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(o, sa, ma, sb, mb));
                break;
            end
        end
        idle();
        drain();

        // Random backpressure mixed with random stimulus
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rand_set(o, sa, ma, sb, mb);
                    send(o, sa, ma, sb, mb, model(o, sa, ma, sb, mb), 1'b0);
                end
                idle();
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 3) != 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
